// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one N-bit adder between REQS requesters.
// The granted operands are summed and held with carry/overflow flags until the consumer accepts.
module adder_arbiter #(
  parameter int N    = 16,
  parameter int REQS = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REQS-1:0]     req_valid,
  input  logic [REQS*N-1:0]   req_a,
  input  logic [REQS*N-1:0]   req_b,
  output logic [REQS-1:0]     req_ready,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [N-1:0]        rsp_data,
  output logic                rsp_carry,
  output logic                rsp_ovf,
  input  logic                rsp_ready
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t                state, state_nxt;
  logic [IDW-1:0]        rr_ptr, rr_nxt, gnt_id;
  logic                  gnt_any, load;
  int                    gnt_idx;
  logic [REQS-1:0]       gnt_onehot;
  logic signed [N-1:0]   a_p0, b_p0;
  logic [N:0]            sum_p0;

  // Same-sign operands whose result sign flips have overflowed.
  function automatic logic ovf_flag(input logic signed [N-1:0] a,
                                    input logic signed [N-1:0] b,
                                    input logic [N-1:0] s);
    return (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
  endfunction

  // Rotating search starting at rr_ptr; modulo keeps indices below REQS.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = 0;
    for (int k = 0; k < REQS; k++) begin
      idx = (int'(rr_ptr) + k) % REQS;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign gnt_id     = IDW'(gnt_idx);
  assign gnt_onehot = gnt_any ? (REQS'(1) << gnt_idx) : '0;
  assign req_ready  = (rst_n && state == IDLE) ? gnt_onehot : '0;

  // Stage p0: operand select and the (N+1)-bit sum, registered into rsp_* below.
  assign a_p0   = req_a[gnt_idx*N +: N];
  assign b_p0   = req_b[gnt_idx*N +: N];
  assign sum_p0 = {1'b0, a_p0} + {1'b0, b_p0};

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          load      = 1'b1;
          state_nxt = RESP;
          rr_nxt    = IDW'((gnt_idx + 1) % REQS);
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      if (load) begin
        rsp_valid <= 1'b1;
        rsp_id    <= gnt_id;
        rsp_data  <= sum_p0[N-1:0];
        rsp_carry <= sum_p0[N];
        rsp_ovf   <= ovf_flag(a_p0, b_p0, sum_p0[N-1:0]);
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level round-robin/arithmetic model.
module tb_adder_arbiter;
  localparam int N = 16, REQS = 4, IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [REQS-1:0]   req_valid = '0;
  logic [REQS*N-1:0] req_a = '0, req_b = '0;
  logic [REQS-1:0]   req_ready;
  logic              rsp_valid, rsp_carry, rsp_ovf;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_data;
  logic              rsp_ready = 1'b0;

  adder_arbiter #(.N(N), .REQS(REQS), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int a_in [REQS];
  int b_in [REQS];

  // Reference model state
  bit m_busy = 0;
  int m_rr = 0, m_id = 0, m_data = 0, m_carry = 0, m_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant(input logic [REQS-1:0] v);
    if (m_busy) return -1;
    for (int k = 0; k < REQS; k++)
      if (v[(m_rr + k) % REQS]) return (m_rr + k) % REQS;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_rr = 0; m_id = 0; m_data = 0; m_carry = 0; m_ovf = 0;
  endtask

  task automatic check_rsp(input string tag);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'(m_busy));
    chk({tag, "_id"},    32'(rsp_id),    32'(m_id));
    chk({tag, "_data"},  32'(rsp_data),  32'(m_data));
    chk({tag, "_carry"}, 32'(rsp_carry), 32'(m_carry));
    chk({tag, "_ovf"},   32'(rsp_ovf),   32'(m_ovf));
  endtask

  // One clock: drive inputs, check the combinational grant, clock, check the held result.
  task automatic step(input logic [REQS-1:0] v, input logic rdy, input string tag);
    int g, s, sa, sb;
    for (int i = 0; i < REQS; i++) begin
      req_a[i*N +: N] = N'(a_in[i]);
      req_b[i*N +: N] = N'(b_in[i]);
    end
    req_valid = v;
    rsp_ready = rdy;
    #1;
    g = exp_grant(v);
    chk({tag, "_ready"}, 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    if (g >= 0) begin
      s  = a_in[g] + b_in[g];
      sa = (a_in[g] >= 32768) ? a_in[g] - 65536 : a_in[g];
      sb = (b_in[g] >= 32768) ? b_in[g] - 65536 : b_in[g];
      m_data  = s % 65536;
      m_carry = s / 65536;
      m_ovf   = (sa + sb > 32767 || sa + sb < -32768) ? 1 : 0;
      m_id    = g;
      m_busy  = 1;
      m_rr    = (g + 1) % REQS;
    end else if (m_busy && rdy) begin
      m_busy = 0;
    end
    #1;
    check_rsp(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    model_reset();
    chk({tag, "_rst_ready"}, 32'(req_ready), 32'd0);
    check_rsp({tag, "_rst"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < REQS; i++) begin a_in[i] = 0; b_in[i] = 0; end
    @(posedge clk);
    do_reset("reset");

    // Requester 0 basic add
    a_in[0] = 'h1800; b_in[0] = 'h1800;
    step(4'b0001, 1'b1, "t1_req");
    chk("t1_sum", 32'(rsp_data), 32'h3000);
    chk("t1_id", 32'(rsp_id), 32'd0);
    step(4'b0000, 1'b1, "t1_done");
    chk("t1_drop", 32'(rsp_valid), 32'd0);

    // Requester 2 carry then overflow
    a_in[2] = 'hFFFF; b_in[2] = 'hFFFF;
    step(4'b0100, 1'b1, "t2a");
    chk("t2a_sum", 32'(rsp_data), 32'hFFFE);
    chk("t2a_carry", 32'(rsp_carry), 32'd1);
    chk("t2a_ovf", 32'(rsp_ovf), 32'd0);
    step(4'b0000, 1'b1, "t2a_done");
    a_in[2] = 'h7FFF; b_in[2] = 'h0001;
    step(4'b0100, 1'b1, "t2b");
    chk("t2b_sum", 32'(rsp_data), 32'h8000);
    chk("t2b_carry", 32'(rsp_carry), 32'd0);
    chk("t2b_ovf", 32'(rsp_ovf), 32'd1);
    step(4'b0000, 1'b1, "t2b_done");

    // All requesters valid from reset: rotation 0,1,2,3,0
    do_reset("t3");
    for (int i = 0; i < REQS; i++) begin a_in[i] = i * 16; b_in[i] = i; end
    for (int c = 0; c < 9; c++) begin
      step(4'b1111, 1'b1, "t3_rr");
      if (c % 2 == 0) chk("t3_order", 32'(rsp_id), 32'(order[c/2]));
    end
    step(4'b0000, 1'b1, "t3_done");

    // Stall with rsp_ready low; requester 3 waits
    a_in[1] = 'h1234; b_in[1] = 'h0101; a_in[3] = 'h0F00; b_in[3] = 'h00F0;
    step(4'b1010, 1'b0, "t4_g1");
    chk("t4_id1", 32'(rsp_id), 32'd1);
    for (int c = 0; c < 3; c++) begin
      step(4'b1000, 1'b0, "t4_hold");
      chk("t4_hold_data", 32'(rsp_data), 32'h1335);
    end
    step(4'b1000, 1'b1, "t4_release");
    step(4'b1000, 1'b1, "t4_g3");
    chk("t4_id3", 32'(rsp_id), 32'd3);

    // Async reset while in RESP with rr_ptr=2
    step(4'b0000, 1'b1, "t5_idle");
    step(4'b0010, 1'b0, "t5_g1");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_rsp("t5_async");
    chk("t5_async_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 1'b1, "t5_after");
    chk("t5_first", 32'(rsp_id), 32'd0);

    // Idle period leaves rr_ptr alone
    step(4'b0000, 1'b1, "t6_ret");
    for (int c = 0; c < 10; c++) step(4'b0000, 1'b1, "t6_idle");
    step(4'b1000, 1'b1, "t6_g3");
    chk("t6_id3", 32'(rsp_id), 32'd3);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < REQS; i++) begin
        a_in[i] = int'($urandom_range(65535));
        b_in[i] = int'($urandom_range(65535));
      end
      step(REQS'($urandom), 1'($urandom_range(3) != 0), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
